uart_tx_cfg: RTL and testbench

Second-generation UART transmitter with a runtime-programmable baud divisor, frame length, parity mode and stop-bit count. A small input FIFO with a valid/ready handshake sits in front of it. It serialises words onto tx LSB-first, with exact per-bit timing, because the baud counter restarts at every frame start. It sits between processor/stream logic and the board TX pin.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_sync_fifo.sv | 48 ++++
 rtl/uart_tx_cfg.sv | 156 +++++++++++++++
 tb/tb_uart_tx_cfg.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: parity modes, transmitter FSM
// states and clamping helpers for runtime configuration.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  // Divisors below 2 would leave no room for a bit boundary.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < 32'd2) ? 32'd2 : div;
  endfunction

  function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
    if (len < 4'd5) return 4'd5;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy level; full/empty come from an extra pointer
// bit so every entry is usable.
module uart_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [Width-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [Width-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(Depth):0] o_level
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0]   r_wptr;
  logic [AddrW:0]   r_rptr;
  logic [Width-1:0] r_mem [Depth];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AddrW] != r_rptr[AddrW]) &&
                     (r_wptr[AddrW-1:0] == r_rptr[AddrW-1:0]);
  assign o_level   = r_wptr - r_rptr;
  assign o_rdata   = r_mem[r_rptr[AddrW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AddrW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with runtime divisor/length/parity/stop configuration,
// latched per frame, fed from a small input FIFO.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 9,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [3:0]                    cfg_len,
  input  logic [1:0]                    cfg_par,
  input  logic                          cfg_stop2,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_head;
  logic              w_bit_end;
  logic              w_frame_end;
  logic              w_par_bit;

  logic              r_alive;
  tx_state_e         r_state;
  logic [DIV_W-1:0]  r_cnt;
  logic [DIV_W-1:0]  r_div;
  logic [3:0]        r_len;
  logic [3:0]        r_bit;
  logic [1:0]        r_par_mode;
  logic              r_stop2;
  logic              r_par;
  logic [DATA_W-1:0] r_shift;
  logic              r_tx;
  logic              r_busy;
  logic              r_tx_done;

  uart_sync_fifo #(
    .Width (DATA_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (s_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  // r_alive keeps s_ready low while reset is held.
  assign s_ready     = r_alive && !w_full;
  assign w_push      = s_valid && s_ready;
  assign w_bit_end   = (r_cnt == r_div - DIV_W'(1));
  assign w_frame_end = (r_state == StStop) && w_bit_end && (!r_stop2 || r_bit == 4'd1);
  assign w_pop       = !w_empty && ((r_state == StIdle) || w_frame_end);

  always_comb begin
    w_par_bit = 1'b1;
    case (r_par_mode)
      PAR_EVEN: w_par_bit = r_par;
      PAR_ODD:  w_par_bit = ~r_par;
      default:  w_par_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_alive    <= 1'b0;
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_div      <= DIV_W'(2);
      r_len      <= 4'd5;
      r_bit      <= '0;
      r_par_mode <= PAR_NONE;
      r_stop2    <= 1'b0;
      r_par      <= 1'b0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      r_alive   <= 1'b1;
      r_busy    <= (r_state != StIdle) || !w_empty;
      r_tx_done <= w_frame_end;

      // tx follows the state one cycle later so it comes straight off a flop.
      case (r_state)
        StStart:  r_tx <= 1'b0;
        StData:   r_tx <= r_shift[0];
        StParity: r_tx <= w_par_bit;
        default:  r_tx <= 1'b1;
      endcase

      if (w_pop) begin
        r_state    <= StStart;
        r_cnt      <= '0;
        r_bit      <= '0;
        r_par      <= 1'b0;
        r_shift    <= w_head;
        r_div      <= DIV_W'(clamp_div(32'(cfg_div)));
        r_len      <= clamp_len(cfg_len, 4'(DATA_W));
        r_par_mode <= cfg_par;
        r_stop2    <= cfg_stop2;
      end else if (r_state != StIdle) begin
        if (!w_bit_end) begin
          r_cnt <= r_cnt + DIV_W'(1);
        end else begin
          r_cnt <= '0;
          case (r_state)
            StStart: begin
              r_state <= StData;
              r_bit   <= '0;
            end
            StData: begin
              r_shift <= r_shift >> 1;
              r_par   <= r_par ^ r_shift[0];
              if (r_bit == r_len - 4'd1) begin
                r_bit   <= '0;
                r_state <= (r_par_mode != PAR_NONE) ? StParity : StStop;
              end else begin
                r_bit <= r_bit + 4'd1;
              end
            end
            StParity: begin
              r_state <= StStop;
              r_bit   <= '0;
            end
            StStop: begin
              if (w_frame_end) r_state <= StIdle;
              else             r_bit   <= r_bit + 4'd1;
            end
            default: r_state <= StIdle;
          endcase
        end
      end
    end
  end

  assign tx      = r_tx;
  assign busy    = r_busy;
  assign tx_done = r_tx_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: table of single frames plus hand-written sequences;
// a serial monitor checks every frame cycle-by-cycle against a scoreboard.
module tb_uart_tx_cfg;

  localparam int unsigned DATA_W     = 9;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned DIV_W      = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [8:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] cfg_div = 16'd16;
  logic [3:0]  cfg_len = 4'd8;
  logic [1:0]  cfg_par = 2'b00;
  logic        cfg_stop2 = 1'b0;
  logic        tx;
  logic        busy;
  logic        tx_done;
  logic [3:0]  fifo_level;

  typedef struct {
    logic [8:0] data;
    int         div;
    int         len;
    logic [1:0] par;
    logic       stop2;
    logic       exp_par;
    int         exp_cycles;
  } vec_t;

  vec_t sb[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   frames_done = 0;
  int   stall_lvl = -1;
  bit   mon_busy = 1'b0;

  uart_tx_cfg #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .cfg_div    (cfg_div),
    .cfg_len    (cfg_len),
    .cfg_par    (cfg_par),
    .cfg_stop2  (cfg_stop2),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int eff_div(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int eff_len(input int l);
    return (l < 5) ? 5 : ((l > 9) ? 9 : l);
  endfunction

  function automatic logic model_par(input logic [8:0] data, input int len, input logic [1:0] par);
    logic x = 1'b0;
    for (int i = 0; i < eff_len(len); i++) x ^= data[i];
    case (par)
      2'b01:   return x;
      2'b10:   return ~x;
      2'b11:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Caller sits at posedge+#1; returns at accept edge +#1.
  task automatic send_rec(input vec_t v);
    int g = 0;
    s_data  = v.data;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && g < 2000) begin
      stall_lvl = int'(fifo_level);
      @(posedge clk); #1;
      g++;
    end
    if (g >= 2000) begin
      n_vec++; n_miss++;
      $display("FAIL send_timeout: s_ready stayed %b, required 1", s_ready);
    end else begin
      sb.push_back(v);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [8:0] data);
    vec_t v;
    v.data       = data;
    v.div        = int'(cfg_div);
    v.len        = int'(cfg_len);
    v.par        = cfg_par;
    v.stop2      = cfg_stop2;
    v.exp_par    = model_par(data, v.len, v.par);
    v.exp_cycles = eff_div(v.div) * (2 + eff_len(v.len) + ((v.par != 0) ? 1 : 0) +
                   (v.stop2 ? 1 : 0));
    send_rec(v);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((busy !== 1'b0 || mon_busy || sb.size() != 0) && g < 5000) begin
      @(posedge clk); #1;
      g++;
    end
    chk("wait_idle_in_budget", (g < 5000), 1);
  endtask

  task automatic wait_tx_low();
    int g = 0;
    while (tx !== 1'b0 && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    chk("tx_start_seen", tx, 0);
  endtask

  // Serial monitor: pops a record at each falling start edge and checks tx and
  // tx_done on every cycle of the frame.
  initial begin : monitor
    vec_t cur;
    logic ebits [16];
    int   nb, d, l, flen, cyc, done_at, pidx;
    logic parbit;
    bit   err;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        mon_busy = 1'b0;
      end else begin
        if (!mon_busy) begin
          if (tx_done !== 1'b0) begin
            n_vec++; n_miss++;
            $display("FAIL stray_tx_done: got %b outside a frame, required 0", tx_done);
          end
          if (tx === 1'b0) begin
            if (sb.size() == 0) begin
              n_vec++; n_miss++;
              $display("FAIL unexpected_frame: tx fell with no word pending, required idle");
            end else begin
              cur = sb.pop_front();
              d = eff_div(cur.div);
              l = eff_len(cur.len);
              nb = 0;
              ebits[nb++] = 1'b0;
              for (int i = 0; i < l; i++) ebits[nb++] = cur.data[i];
              pidx = nb;
              if (cur.par != 2'b00) ebits[nb++] = model_par(cur.data, cur.len, cur.par);
              ebits[nb++] = 1'b1;
              if (cur.stop2) ebits[nb++] = 1'b1;
              flen = d * nb;
              cyc = 0; done_at = -1; err = 1'b0; parbit = 1'bx;
              mon_busy = 1'b1;
            end
          end
        end
        if (mon_busy) begin
          if (tx !== ebits[cyc / d]) begin
            if (!err) $display("FAIL frame_%0h_tx: cycle %0d got %b required %b",
                               cur.data, cyc, tx, ebits[cyc / d]);
            err = 1'b1;
          end
          if (tx_done === 1'b1 && done_at < 0) done_at = cyc;
          if (tx_done !== (cyc == flen - 1)) begin
            if (!err) $display("FAIL frame_%0h_done: cycle %0d got %b", cur.data, cyc, tx_done);
            err = 1'b1;
          end
          if (cyc == d * pidx + d / 2) parbit = tx;
          cyc++;
          if (cyc == flen) begin
            mon_busy = 1'b0;
            frames_done++;
            chk($sformatf("frame_%0h_bits_ok", cur.data), err, 0);
            chk($sformatf("frame_%0h_cycles", cur.data), done_at + 1, cur.exp_cycles);
            if (cur.par != 2'b00) chk($sformatf("frame_%0h_parity", cur.data), parbit, cur.exp_par);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tbl [9];
    int   lvl1, lvl2, lvl3, t, dones, last_done, fall, f0;

    tbl[0] = '{9'h0A5, 16, 8,  2'b00, 1'b0, 1'b0, 160};
    tbl[1] = '{9'h007, 4,  8,  2'b01, 1'b0, 1'b1, 44};
    tbl[2] = '{9'h007, 4,  8,  2'b10, 1'b0, 1'b0, 44};
    tbl[3] = '{9'h007, 4,  8,  2'b11, 1'b0, 1'b1, 44};
    tbl[4] = '{9'h01F, 16, 5,  2'b01, 1'b1, 1'b1, 144};
    tbl[5] = '{9'h03C, 0,  8,  2'b00, 1'b0, 1'b0, 20};
    tbl[6] = '{9'h1A5, 4,  12, 2'b01, 1'b0, 1'b1, 48};
    tbl[7] = '{9'h0FF, 3,  3,  2'b01, 1'b0, 1'b1, 24};
    tbl[8] = '{9'h00A, 1,  6,  2'b10, 1'b0, 1'b1, 18};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_tx_done", tx_done, 0);
    chk("reset_s_ready", s_ready, 0);
    chk("reset_level", fifo_level, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("release_s_ready", s_ready, 1);

    for (int i = 0; i < 9; i++) begin
      cfg_div   = 16'(tbl[i].div);
      cfg_len   = 4'(tbl[i].len);
      cfg_par   = tbl[i].par;
      cfg_stop2 = tbl[i].stop2;
      send_rec(tbl[i]);
      if (i == 0) begin
        chk("lat_busy_at_accept", busy, 0);
        chk("lat_tx_at_accept", tx, 1);
        @(posedge clk); #1;
        chk("lat_busy_n1", busy, 1);
        chk("lat_tx_n1", tx, 1);
        @(posedge clk); #1;
        chk("lat_tx_n2", tx, 0);
      end
      wait_idle();
    end

    // Back-to-back: the idle FSM pops word 1 on the edge that accepts word 2.
    cfg_div = 16'd4; cfg_len = 4'd8; cfg_par = 2'b00; cfg_stop2 = 1'b0;
    send_word(9'h011); lvl1 = int'(fifo_level);
    send_word(9'h022); lvl2 = int'(fifo_level);
    send_word(9'h033); lvl3 = int'(fifo_level);
    chk("b2b_level_1", lvl1, 1);
    chk("b2b_level_2", lvl2, 1);
    chk("b2b_level_3", lvl3, 2);
    t = -1; dones = 0; last_done = -1; fall = -1;
    for (int g = 0; g < 600 && fall < 0; g++) begin
      @(negedge clk);
      if (t < 0 && tx === 1'b0) t = 0;
      if (t >= 0) begin
        if (busy !== 1'b1) begin
          fall = t;
        end else begin
          if (tx_done === 1'b1) begin
            dones++;
            last_done = t;
          end
          t++;
        end
      end
    end
    chk("b2b_done_count", dones, 3);
    chk("b2b_last_done_cycle", last_done, 119);
    chk("b2b_busy_fall_cycle", fall, 120);
    @(posedge clk); #1;
    wait_idle();

    // FIFO full: ten words while frame 1 runs; word 10 must stall at level 8.
    f0 = frames_done;
    stall_lvl = -1;
    for (int k = 0; k < 10; k++) send_word(9'(9'h140 + k));
    chk("full_stall_level", stall_lvl, 8);
    wait_idle();
    chk("full_frames_sent", frames_done - f0, 10);

    // Divisor change mid-frame applies only to the next frame.
    cfg_div = 16'd8;
    send_word(9'h0C3);
    wait_tx_low();
    repeat (20) @(posedge clk);
    #1;
    cfg_div = 16'd20;
    send_word(9'h03C);
    wait_idle();

    // Reset during data bit 3 of 0xF0 (tx low there), with a second word queued.
    cfg_div = 16'd8;
    send_word(9'h0F0);
    send_word(9'h0AA);
    wait_tx_low();
    repeat (34) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tx_done", tx_done, 0);
    chk("midrst_s_ready", s_ready, 0);
    sb.delete();
    @(posedge clk); #1;
    chk("midrst_tx_done_hold", tx_done, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    f0 = frames_done;
    send_word(9'h055);
    wait_idle();
    chk("post_reset_frames", frames_done - f0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
